// File: rtl/soc_pkg.sv
// Shared types and constants for the SoC bus controller slice.
package soc_pkg;

  // Wait-state sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } wait_state_t;

  // Region selects for the lower/upper halves of the address map
  localparam logic [1:0] REGION_ROM   = 2'd0;
  localparam logic [1:0] REGION_RAM   = 2'd1;
  localparam logic [1:0] REGION_VIDEO = 2'd2;

  // I/O port that holds the RAM page register unless overridden
  localparam logic [7:0] DEFAULT_BANK_PORT = 8'h00;

  // Width of the bank register; a single page still gets one bit
  function automatic int bank_width(input int num_banks);
    int w;
    w = $clog2(num_banks);
    return (w < 1) ? 1 : w;
  endfunction

  // Lower half reads come from ROM, lower half writes go to video,
  // upper half is banked RAM for both directions
  function automatic logic [1:0] region_of(input logic addr15, input logic is_write);
    if (addr15)
      return REGION_RAM;
    else if (is_write)
      return REGION_VIDEO;
    else
      return REGION_ROM;
  endfunction

endpackage

// File: rtl/soc_bus_ctrl_if.sv
// CPU bus plus memory/video side signals of the bus controller.
interface soc_bus_ctrl_if
  import soc_pkg::*;
#(
  parameter int ROM_AW    = 12,
  parameter int RAM_AW    = 12,
  parameter int NUM_BANKS = 4
) ();

  localparam int BANK_W = bank_width(NUM_BANKS);

  logic [15:0]             cpu_addr;
  logic [7:0]              cpu_dout;
  logic                    cpu_mreq_n;
  logic                    cpu_iorq_n;
  logic                    cpu_rd_n;
  logic                    cpu_wr_n;
  logic [7:0]              cpu_din;
  logic                    cpu_wait_n;
  logic                    cpu_reset_n;
  logic [ROM_AW-1:0]       rom_addr;
  logic [7:0]              rom_q;
  logic [BANK_W+RAM_AW-1:0] ram_addr;
  logic                    ram_we;
  logic [7:0]              ram_q;
  logic                    vid_we;
  logic [13:0]             vid_addr;
  logic [7:0]              vid_data;
  logic [BANK_W-1:0]       bank;

  // CPU and memory models side
  modport master (
    output cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
    output rom_q, ram_q,
    input  cpu_din, cpu_wait_n, cpu_reset_n,
    input  rom_addr, ram_addr, ram_we, vid_we, vid_addr, vid_data, bank
  );

  // Controller side
  modport slave (
    input  cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
    input  rom_q, ram_q,
    output cpu_din, cpu_wait_n, cpu_reset_n,
    output rom_addr, ram_addr, ram_we, vid_we, vid_addr, vid_data, bank
  );

endinterface

// File: rtl/soc_bus_ctrl_reset_gen.sv
// Holds the CPU in reset for a fixed number of clocks after system reset.
module soc_reset_gen #(
  parameter int RESET_CYCLES = 256
) (
  input  logic cpu_clk,
  input  logic reset,
  output logic cpu_reset_n
);

  localparam logic [15:0] LAST_COUNT = 16'(RESET_CYCLES - 1);

  logic [15:0] count_q;
  logic        done_q;

  // Count edges until the last one, then release the CPU and freeze
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else if (!done_q) begin
      count_q <= count_q + 16'd1;
      if (count_q == LAST_COUNT)
        done_q <= 1'b1;
    end
  end

  assign cpu_reset_n = done_q;

endmodule

// File: rtl/soc_bus_ctrl.sv
// Glue between an 8-bit CPU and its ROM, banked RAM and video memory:
// address decode, bank register, write strobes and read wait states.
module soc_bus_ctrl
  import soc_pkg::*;
#(
  parameter int         ROM_AW       = 12,
  parameter int         RAM_AW       = 12,
  parameter int         NUM_BANKS    = 4,
  parameter int         WAIT_CYCLES  = 1,
  parameter logic [7:0] BANK_PORT    = DEFAULT_BANK_PORT,
  parameter int         RESET_CYCLES = 256
) (
  input  logic          cpu_clk,
  input  logic          reset,
  soc_bus_ctrl_if.slave bus
);

  localparam int         BANK_W    = bank_width(NUM_BANKS);
  localparam bit         WAIT_EN   = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic              cpu_reset_n;
  logic              mem_rd;
  logic              mem_wr;
  logic              io_wr;
  logic              port_hit;
  logic              vid_cond;
  logic              bank_cond;
  logic              vid_prev_q;
  logic              bank_prev_q;
  logic              rd_prev_q;
  logic              rd_start;
  logic [BANK_W-1:0] bank_q;
  wait_state_t       state_q;
  wait_state_t       state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              unused_addr_bit;

  soc_reset_gen #(
    .RESET_CYCLES (RESET_CYCLES)
  ) u_reset_gen (
    .cpu_clk     (cpu_clk),
    .reset       (reset),
    .cpu_reset_n (cpu_reset_n)
  );

  assign mem_rd    = !bus.cpu_mreq_n && !bus.cpu_rd_n;
  assign mem_wr    = !bus.cpu_mreq_n && !bus.cpu_wr_n;
  assign io_wr     = !bus.cpu_iorq_n && !bus.cpu_wr_n;
  assign port_hit  = (bus.cpu_addr[7:0] == BANK_PORT);
  assign vid_cond  = mem_wr && (region_of(bus.cpu_addr[15], 1'b1) == REGION_VIDEO);
  assign bank_cond = io_wr && port_hit;
  assign rd_start  = mem_rd && !rd_prev_q;

  // Bit 14 only aliases inside the lower half; nothing decodes it
  assign unused_addr_bit = bus.cpu_addr[14];

  // Remember last cycle's strobe conditions for first-cycle detection
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      vid_prev_q  <= 1'b0;
      bank_prev_q <= 1'b0;
      rd_prev_q   <= 1'b0;
    end else begin
      vid_prev_q  <= vid_cond;
      bank_prev_q <= bank_cond;
      rd_prev_q   <= mem_rd;
    end
  end

  // Bank register loads once per I/O write strobe, only with the CPU running
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset)
      bank_q <= '0;
    else if (cpu_reset_n && bank_cond && !bank_prev_q)
      bank_q <= bus.cpu_dout[BANK_W-1:0];
  end

  // Wait sequencer state and wait-cycle counter
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stretch the start of each memory read, then hold off until strobe release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (WAIT_EN && rd_start) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (!mem_rd)
          state_d = ST_IDLE;
        else if (cnt_q == WAIT_LAST)
          state_d = ST_HOLD;
        else
          cnt_d = cnt_q + 4'd1;
      end
      ST_HOLD: begin
        if (!mem_rd)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!cpu_reset_n)
      state_d = ST_IDLE;
  end

  // Read data mux: I/O space first, then ROM/RAM by address half
  always_comb begin
    bus.cpu_din = 8'hFF;
    if (!bus.cpu_iorq_n) begin
      if (port_hit)
        bus.cpu_din = 8'(bank_q);
    end else if (region_of(bus.cpu_addr[15], 1'b0) == REGION_RAM) begin
      bus.cpu_din = bus.ram_q;
    end else begin
      bus.cpu_din = bus.rom_q;
    end
  end

  assign bus.cpu_wait_n  = (state_q != ST_WAIT);
  assign bus.cpu_reset_n = cpu_reset_n;
  assign bus.rom_addr    = bus.cpu_addr[ROM_AW-1:0];
  assign bus.ram_addr    = {bank_q, bus.cpu_addr[RAM_AW-1:0]};
  assign bus.ram_we      = mem_wr && cpu_reset_n &&
                           (region_of(bus.cpu_addr[15], 1'b1) == REGION_RAM);
  assign bus.vid_we      = vid_cond && !vid_prev_q && cpu_reset_n;
  assign bus.vid_addr    = bus.cpu_addr[13:0];
  assign bus.vid_data    = bus.cpu_dout;
  assign bus.bank        = bank_q;

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// Directed bench for soc_bus_ctrl with simple synchronous ROM/RAM models.
module tb_soc_bus_ctrl;
  import soc_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   hits;
  int   lows;

  soc_bus_ctrl_if #(.ROM_AW(12), .RAM_AW(12), .NUM_BANKS(4)) bus ();

  soc_bus_ctrl #(
    .ROM_AW       (12),
    .RAM_AW       (12),
    .NUM_BANKS    (4),
    .WAIT_CYCLES  (2),
    .BANK_PORT    (8'h00),
    .RESET_CYCLES (256)
  ) dut (
    .cpu_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM returns addr^0x5A, RAM returns addr^0xC3, one clock after the address
  always @(posedge clk) begin
    bus.rom_q <= bus.rom_addr[7:0] ^ 8'h5A;
    bus.ram_q <= bus.ram_addr[7:0] ^ 8'hC3;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] addr, input logic [7:0] dout,
                                input logic mreq_n, input logic iorq_n,
                                input logic rd_n, input logic wr_n);
    bus.cpu_addr   = addr;
    bus.cpu_dout   = dout;
    bus.cpu_mreq_n = mreq_n;
    bus.cpu_iorq_n = iorq_n;
    bus.cpu_rd_n   = rd_n;
    bus.cpu_wr_n   = wr_n;
  endtask

  task automatic bus_idle();
    apply_stimulus(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  // One complete I/O write to the bank port, strobe held two cycles
  task automatic io_out(input logic [7:0] data);
    apply_stimulus(16'h0000, data, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    bus_idle();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus_idle();
    #2;
    check_output("rst_cpu_reset_n", 16'(bus.cpu_reset_n), 16'h0);
    check_output("rst_wait_n",      16'(bus.cpu_wait_n),  16'h1);
    check_output("rst_bank",        16'(bus.bank),        16'h0);
    check_output("rst_vid_we",      16'(bus.vid_we),      16'h0);

    tick();
    reset = 1'b0;
    // Count 256 edges; try bank and RAM writes while the CPU is still held
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      if (i == 1)
        apply_stimulus(16'h8000, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0);
      if (i == 2) begin
        check_output("hold_ram_we", 16'(bus.ram_we), 16'h0);
        apply_stimulus(16'h0000, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      if (i == 4) begin
        check_output("hold_bank", 16'(bus.bank), 16'h0);
        bus_idle();
      end
      if (i == 255)
        check_output("cpu_reset_n_edge255", 16'(bus.cpu_reset_n), 16'h0);
      if (i == 256)
        check_output("cpu_reset_n_edge256", 16'(bus.cpu_reset_n), 16'h1);
    end
    tick();
    tick();
    check_output("cpu_reset_n_stays", 16'(bus.cpu_reset_n), 16'h1);

    // OUT (0x00),0x03 with a data change mid-strobe that must not reload
    apply_stimulus(16'h0000, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("bank_load", 16'(bus.bank), 16'h3);
    bus.cpu_dout = 8'h01;
    tick();
    check_output("bank_no_reload", 16'(bus.bank), 16'h3);
    bus_idle();
    tick();

    // RAM write 0xA5 to 0x8010 on page 3
    apply_stimulus(16'h8010, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_output("ram_we_strobe", 16'(bus.ram_we),   16'h1);
    check_output("ram_addr",      16'(bus.ram_addr), 16'h3010);
    check_output("ram_vid_we",    16'(bus.vid_we),   16'h0);
    tick();
    bus_idle();
    @(negedge clk);
    check_output("ram_we_release", 16'(bus.ram_we), 16'h0);
    tick();

    // Video write 0x7E to 0x1234, strobe held three cycles
    hits = 0;
    lows = 0;
    apply_stimulus(16'h1234, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (bus.vid_we)      hits++;
      if (!bus.cpu_wait_n) lows++;
      if (j == 0) begin
        check_output("vid_addr",   16'(bus.vid_addr), 16'h1234);
        check_output("vid_data",   16'(bus.vid_data), 16'h007E);
        check_output("vid_ram_we", 16'(bus.ram_we),   16'h0);
      end
    end
    check_output("vid_we_pulses",  16'(hits), 16'h1);
    check_output("write_no_wait",  16'(lows), 16'h0);
    tick();
    bus_idle();
    tick();

    // ROM read at 0x0100: two wait cycles, no second wait in the same strobe
    lows = 0;
    apply_stimulus(16'h0100, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (!bus.cpu_wait_n) lows++;
    end
    check_output("rom_wait_cycles", 16'(lows),           16'h2);
    check_output("rom_wait_n_end",  16'(bus.cpu_wait_n), 16'h1);
    check_output("rom_din",         16'(bus.cpu_din),    16'h005A);
    tick();
    bus_idle();
    tick();
    check_output("fsm_idle", 16'(dut.state_q), 16'(ST_IDLE));

    // RAM read at 0x8010 on page 3
    lows = 0;
    apply_stimulus(16'h8010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (!bus.cpu_wait_n) lows++;
    end
    check_output("ram_wait_cycles", 16'(lows),        16'h2);
    check_output("ram_din",         16'(bus.cpu_din), 16'h00D3);
    tick();
    bus_idle();
    tick();

    // Upper data bits ignored: 0xFE selects page 2
    io_out(8'hFE);
    check_output("bank_mask", 16'(bus.bank), 16'h2);

    // IN from the bank port (upper address byte is don't-care) and another port
    lows = 0;
    apply_stimulus(16'h5500, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_output("in_bank_port", 16'(bus.cpu_din), 16'h0002);
    tick();
    @(negedge clk);
    if (!bus.cpu_wait_n) lows++;
    check_output("io_no_wait", 16'(lows), 16'h0);
    apply_stimulus(16'h0001, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check_output("in_other_port", 16'(bus.cpu_din), 16'h00FF);
    tick();
    bus_idle();
    tick();

    // Asynchronous reset in the middle of a wait on page 3
    io_out(8'h03);
    apply_stimulus(16'h0100, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    check_output("pre_rst_wait_n", 16'(bus.cpu_wait_n), 16'h0);
    check_output("pre_rst_bank",   16'(bus.bank),       16'h3);
    #1;
    reset = 1'b1;
    #1;
    check_output("async_wait_n",      16'(bus.cpu_wait_n),  16'h1);
    check_output("async_bank",        16'(bus.bank),        16'h0);
    check_output("async_cpu_reset_n", 16'(bus.cpu_reset_n), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_bus_ctrl.md
SOC_BUS_CTRL -- requirements
Module: soc_bus_ctrl

Interface
REQ-001 Parameter: ROM_AW, default 12, ROM address width (ROM occupies 0x0000-0x7FFF for reads, aliased every 2^ROM_AW bytes).
REQ-002 Parameter: RAM_AW, default 12, RAM page address width (RAM occupies 0x8000-0xFFFF, aliased every 2^RAM_AW bytes).
REQ-003 Parameter: NUM_BANKS, default 4, number of RAM pages (power of two, 1..256); BANK_W = max(1, clog2(NUM_BANKS)).
REQ-004 Parameter: WAIT_CYCLES, default 1, wait states inserted per memory read (0..15).
REQ-005 Parameter: BANK_PORT, default 8'h00, I/O port number of the bank register.
REQ-006 Parameter: RESET_CYCLES, default 256, CPU reset hold length in cpu_clk cycles (1..65535).
REQ-007 cpu_clk  in  1  sole clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 cpu_addr  in  16  CPU address bus.
REQ-010 cpu_dout  in  8  CPU write data.
REQ-011 cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n  in  1 each  CPU strobes, active-low.
REQ-012 cpu_din  out  8  read data to CPU.
REQ-013 cpu_wait_n  out  1  wait request to CPU, active-low.
REQ-014 cpu_reset_n  out  1  CPU reset, active-low.
REQ-015 rom_addr  out  ROM_AW  = cpu_addr[ROM_AW-1:0]; rom_q  in  8  synchronous ROM data.
REQ-016 ram_addr  out  BANK_W+RAM_AW  = {bank, cpu_addr[RAM_AW-1:0]}; ram_we  out  1; ram_q  in  8.
REQ-017 vid_we  out  1  one-cycle write pulse; vid_addr  out  14  = cpu_addr[13:0]; vid_data  out  8  = cpu_dout.
REQ-018 bank  out  BANK_W  current RAM page.

Function
REQ-019 Reset counter SHALL hold cpu_reset_n low until RESET_CYCLES rising edges after reset deasserts, then drive it high and stop counting.
REQ-020 Memory read decode SHALL be: cpu_din = ram_q when cpu_addr[15]=1, else rom_q.
REQ-021 I/O read decode SHALL return {(8-BANK_W)'0, bank} when low address byte = BANK_PORT, else 8'hFF.
REQ-022 ram_we SHALL be high combinationally while cpu_mreq_n=0, cpu_wr_n=0, cpu_addr[15]=1 and cpu_reset_n=1.
REQ-023 vid_we SHALL pulse for exactly one cycle, on the first cycle cpu_mreq_n=0, cpu_wr_n=0, cpu_addr[15]=0 holds after any cycle where it did not (edge-detected).
REQ-024 Bank register SHALL load cpu_dout[BANK_W-1:0] on the first cycle of an I/O write (cpu_iorq_n=0, cpu_wr_n=0, cpu_addr[7:0]=BANK_PORT); upper data bits ignored, repeated cycles of the same strobe do not reload.
REQ-025 Wait FSM states: IDLE, WAIT, HOLD.
REQ-026 IDLE -> WAIT when a memory read starts (cpu_mreq_n and cpu_rd_n both low, previous cycle not) and WAIT_CYCLES>0; cpu_wait_n low in WAIT.
REQ-027 WAIT counts WAIT_CYCLES cycles, then -> HOLD with cpu_wait_n high.
REQ-028 HOLD -> IDLE when cpu_mreq_n or cpu_rd_n returns high; no new wait generated within the same strobe.
REQ-029 WAIT_CYCLES=0: FSM stays in IDLE, cpu_wait_n constant high.
REQ-030 Write cycles and I/O cycles SHALL never assert cpu_wait_n low.
REQ-031 While cpu_reset_n=0: ram_we, vid_we low, no bank writes, FSM forced to IDLE.

Reset
REQ-032 Asserting reset SHALL immediately set: counter 0, cpu_reset_n 0, bank 0, FSM IDLE, cpu_wait_n 1, vid_we 0, edge-detect registers to "inactive".
REQ-033 Reset asserted mid-wait SHALL release cpu_wait_n high in the same instant (asynchronous).

Structure
REQ-034 Shared package soc_pkg SHALL hold the FSM state enumeration, the region-select constants (ROM/RAM/VIDEO) and the default BANK_PORT.
REQ-035 One sub-module, soc_reset_gen (RESET_CYCLES counter producing cpu_reset_n), SHALL be instantiated; the rest is flat.

Verification
REQ-036 Reset released, RESET_CYCLES=256 -> cpu_reset_n low for 256 cycles, high on edge 256, stays high.
REQ-037 OUT (0x00),0x03 with NUM_BANKS=4, then write 0xA5 to 0x8010 -> ram_addr=0x3010, ram_we high during strobe, bank=3.
REQ-038 Write 0x7E to 0x1234 with strobe held 3 cycles -> vid_we high exactly 1 cycle, vid_addr=0x1234, vid_data=0x7E, ram_we low.
REQ-039 Read 0x0100, WAIT_CYCLES=2 -> cpu_wait_n low exactly 2 cycles, then high; cpu_din=rom_q; FSM returns to IDLE after strobe release.
REQ-040 IN from port 0x00 after bank=2 -> cpu_din=0x02; IN from port 0x01 -> cpu_din=0xFF.
REQ-041 Reset asserted during WAIT with bank=3 -> cpu_wait_n 1, bank 0, cpu_reset_n 0 before next clock edge.
